// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus an iterative multiply/divide unit
// with hi/lo result registers (one bit per cycle).
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] p, pn, pm, pd, prod;
  logic [W-1:0]   m, ma, mb, qv, rv, rn, dif;
  logic [W-1:0]   add, sub;
  logic [W:0]     sum, sh;
  logic           ge, sgn, acc, mdo, mto, dzero, last;
  logic           isdiv, negq, negr;

  assign add = a + b;
  assign sub = a - b;

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      4'h0: begin
        y   = add;
        ovf = (a[W-1] == b[W-1]) && (add[W-1] != a[W-1]);
      end
      4'h1: begin
        y   = sub;
        ovf = (a[W-1] != b[W-1]) && (sub[W-1] != a[W-1]);
      end
      4'h2: y = a & b;
      4'h3: y = a | b;
      4'h4: y = a ^ b;
      4'h5: y = ~(a | b);
      4'h6: y = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      4'h7: y = {{(W-1){1'b0}}, a < b};
      4'hC: y = hi;
      4'hD: y = lo;
      default: y = '0;
    endcase
  end

  assign z = (y == '0);

  // signed ops iterate on magnitudes; signs are re-applied at the end
  assign sgn   = op[0];
  assign ma    = (sgn && a[W-1]) ? -a : a;
  assign mb    = (sgn && b[W-1]) ? -b : b;
  assign acc   = start && op[3] && (state != RUN);
  assign mdo   = acc && !op[2];
  assign mto   = acc && (op[2:1] == 2'b11);
  assign dzero = op[1] && (b == '0);

  assign sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : '0);
  assign pm  = {sum, p[W-1:1]};

  assign sh  = {p[2*W-1:W], p[W-1]};
  assign ge  = sh >= {1'b0, m};
  assign dif = sh[W-1:0] - m;
  assign rn  = ge ? dif : sh[W-1:0];
  assign pd  = {rn, p[W-2:0], ge};

  assign pn   = isdiv ? pd : pm;
  assign qv   = pn[W-1:0];
  assign rv   = pn[2*W-1:W];
  assign prod = negq ? -pn : pn;
  assign last = (cnt == CW'(W-1));

  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
      dz    <= 1'b0;
      isdiv <= 1'b0;
      negq  <= 1'b0;
      negr  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          p   <= pn;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= FIN;
            if (isdiv) begin
              lo <= negq ? -qv : qv;
              hi <= negr ? -rv : rv;
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        default: begin
          state <= IDLE;
          if (mto) begin
            if (op[0]) lo <= a;
            else       hi <= a;
          end
          if (mdo) begin
            dz    <= dzero;
            isdiv <= op[1];
            negq  <= sgn && (a[W-1] ^ b[W-1]);
            negr  <= sgn && a[W-1];
            cnt   <= '0;
            if (dzero) begin
              state <= FIN;
              hi    <= a;
              lo    <= '1;
            end else begin
              state <= RUN;
              p     <= {{W{1'b0}}, (op[1] ? ma : mb)};
              m     <= op[1] ? mb : ma;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: random + directed checks of alu_muldiv against
// an arithmetic reference model.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         start = 1'b0;
  logic [W-1:0] y, hi, lo;
  logic         z, ovf, busy, done, dz;

  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;
  logic         mdz = 1'b0;

  int nvec = 0;
  int nbad = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .start(start), .y(y), .z(z), .ovf(ovf), .hi(hi),
    .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void alu_ref(input logic [3:0] o,
      input logic [31:0] x, input logic [31:0] v,
      output logic [31:0] r, output logic f);
    longint sx, sv, s;
    sx = longint'($signed(x));
    sv = longint'($signed(v));
    f = 1'b0;
    r = '0;
    case (o)
      4'h0: begin
        s = sx + sv; r = x + v;
        f = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1: begin
        s = sx - sv; r = x - v;
        f = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: r = x & v;
      4'h3: r = x | v;
      4'h4: r = x ^ v;
      4'h5: r = ~(x | v);
      4'h6: r = (sx < sv) ? 32'd1 : 32'd0;
      4'h7: r = (x < v) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endfunction

  function automatic void md_ref(input logic [3:0] o,
      input logic [31:0] x, input logic [31:0] v,
      output logic [31:0] rh, output logic [31:0] rl,
      output logic rd);
    logic [63:0] pr;
    longint sx, sv, q, r;
    sx = longint'($signed(x));
    sv = longint'($signed(v));
    rd = 1'b0;
    pr = '0;
    case (o)
      4'h8: pr = 64'(x) * 64'(v);
      4'h9: pr = sx * sv;
      4'hA, 4'hB: begin
        if (v == 0) begin
          pr = {x, 32'hFFFFFFFF};
          rd = 1'b1;
        end else if (o == 4'hA) begin
          pr = {x % v, x / v};
        end else begin
          q = sx / sv;
          r = sx % sv;
          pr = {32'(r), 32'(q)};
        end
      end
      default: pr = '0;
    endcase
    rh = pr[63:32];
    rl = pr[31:0];
  endfunction

  task automatic comb_chk(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] v);
    logic [31:0] er;
    logic ef;
    alu_ref(o, x, v, er, ef);
    @(negedge clk);
    op = o; a = x; b = v;
    #1;
    chk($sformatf("y_op%0d", o), 64'(y), 64'(er));
    chk($sformatf("z_op%0d", o), 64'(z), 64'(er == 0));
    chk($sformatf("ovf_op%0d", o), 64'(ovf), 64'(ef));
  endtask

  task automatic run_seq(input logic [3:0] o, input logic [31:0] x,
      input logic [31:0] v, input bit nowait, input bit poke);
    logic [31:0] eh, el;
    logic ed;
    int n, nb, lat;
    md_ref(o, x, v, eh, el, ed);
    lat = (o[1] && v == 0) ? 1 : W + 1;
    if (!nowait) @(negedge clk);
    op = o; a = x; b = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'hC;
    a = $urandom; b = $urandom;
    n = 1; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (n == 3) begin
        chk("mfhi_hold", 64'(y), 64'(mhi));
        op = 4'hD;
      end
      if (n == 4) chk("mflo_hold", 64'(y), 64'(mlo));
      if (poke && n == 10) begin
        start = 1'b1; op = 4'hB;
        a = $urandom; b = $urandom;
      end
      if (poke && n == 11) begin
        start = 1'b0; op = 4'hC;
      end
      @(negedge clk);
      n++;
    end
    mhi = eh; mlo = el; mdz = ed;
    chk("latency", 64'(n), 64'(lat));
    chk("busy_cycles", 64'(nb), 64'(lat - 1));
    chk("hi", 64'(hi), 64'(mhi));
    chk("lo", 64'(lo), 64'(mlo));
    chk("dz", 64'(dz), 64'(mdz));
  endtask

  initial begin
    logic [3:0] o;
    logic [31:0] x, v;
    bit saw;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    rst_n = 1'b1;

    comb_chk(4'h6, 32'hFFFFFFFF, 32'd1);
    comb_chk(4'h7, 32'hFFFFFFFF, 32'd1);
    comb_chk(4'h0, 32'h7FFFFFFF, 32'd1);
    chk("add_max", 64'(y), 64'h80000000);
    comb_chk(4'h1, 32'h80000000, 32'd1);
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 7));
      x = $urandom;
      v = $urandom;
      if (i % 7 == 0) v = x;
      if (i % 11 == 0) x = 32'h80000000;
      comb_chk(o, x, v);
    end

    run_seq(4'h9, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);
    run_seq(4'hB, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    run_seq(4'hA, 32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_hi", 64'(hi), 64'd1);
    run_seq(4'hA, 32'd5, 32'd0, 1'b0, 1'b0);
    chk("dz_set", 64'(dz), 64'd1);
    run_seq(4'h8, 32'd9, 32'd9, 1'b0, 1'b0);
    chk("dz_clr", 64'(dz), 64'd0);
    run_seq(4'hB, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);

    run_seq(4'h8, $urandom, $urandom, 1'b0, 1'b1);
    run_seq(4'h9, $urandom, $urandom, 1'b1, 1'b0);

    @(negedge clk);
    op = 4'hE; a = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'hF; a = 32'hCAFE_F00D; mhi = 32'h1234_5678;
    chk("mthi", 64'(hi), 64'(mhi));
    chk("mt_busy", 64'(busy) | 64'(done), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; mlo = 32'hCAFE_F00D;
    chk("mtlo", 64'(lo), 64'(mlo));
    op = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("alu_start_ignored", 64'(busy), 64'd0);
    op = 4'hA; #1;
    chk("y_zero_op10", 64'(y), 64'd0);

    for (int i = 0; i < 24; i++) begin
      o = 4'(8 + $urandom_range(0, 3));
      x = $urandom;
      v = $urandom;
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = $urandom_range(1, 9);
        2: begin x = 32'h80000000; v = '1; end
        3: v = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_seq(o, x, v, (i % 4) == 1, i == 5);
    end

    @(negedge clk);
    op = 4'h8; a = $urandom | 32'h1; b = $urandom | 32'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    mhi = '0; mlo = '0; mdz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    chk("abort_quiet", 64'(saw), 64'd0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(4'h9, $urandom, $urandom, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 8..64, even).
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-004 Ports a and b SHALL be inputs, WIDTH bits, the operands.
REQ-005 Port op SHALL be an input, 4 bits, the operation select.
REQ-006 Port start SHALL be an input, 1 bit, requesting a sequential operation (op[3]=1).
REQ-007 Port y SHALL be an output, WIDTH bits, the combinational result.
REQ-008 Port z SHALL be an output, 1 bit, high when y equals zero.
REQ-009 Port ovf SHALL be an output, 1 bit, signed overflow of ADD/SUB, else 0.
REQ-010 Ports hi and lo SHALL be outputs, WIDTH bits each, the registered multiply/divide results.
REQ-011 Port busy SHALL be an output, 1 bit, high while a multiply/divide iterates.
REQ-012 Port done SHALL be an output, 1 bit, a one-cycle pulse when hi/lo receive a new mul/div result.
REQ-013 Port dz SHALL be an output, 1 bit, registered, set by a divide by zero, cleared by the next accepted mul/div.

Function
REQ-014 op 0000..0111 SHALL give y = ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, combinationally, modulo 2^WIDTH.
REQ-015 SLT SHALL give y=1 when a<b as two's-complement values, else 0; SLTU compares unsigned; y zero-extended.
REQ-016 op 1100 (MFHI) and 1101 (MFLO) SHALL drive y = hi or lo combinationally; other op[3]=1 codes drive y=0.
REQ-017 ovf SHALL be 1 for ADD when a and b share a sign differing from y's, and for SUB when a and b differ in sign and y's sign differs from a's.
REQ-018 A start is accepted on a rising edge when start=1, busy=0 and op[3]=1; start with op[3]=0 or while busy=1 SHALL be ignored.
REQ-019 op 1000/1001/1010/1011 SHALL be MULTU/MULT/DIVU/DIV; operands are captured at acceptance, later changes to a/b have no effect.
REQ-020 op 1110 (MTHI) / 1111 (MTLO) accepted SHALL write a into hi / lo at that edge, no busy, no done.
REQ-021 States SHALL be IDLE, RUN, FIN: IDLE->RUN on accepted mul/div; RUN for exactly WIDTH cycles (one bit per cycle, shift-add / restoring); RUN->FIN; FIN->IDLE unconditionally.
REQ-022 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in FIN; hi/lo update at the edge entering FIN; start-to-done latency WIDTH+1 cycles.
REQ-023 A new start SHALL be accepted during FIN (busy=0), giving back-to-back operations.
REQ-024 MULT/MULTU SHALL give {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
REQ-025 DIV/DIVU SHALL give lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
REQ-026 DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0, dz=0.
REQ-027 Divide with b=0 SHALL skip RUN (IDLE->FIN), set lo = all ones, hi = a, dz=1, done one cycle after acceptance.
REQ-028 hi/lo SHALL hold old values during RUN; MFHI/MFLO in RUN return old values.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, hi=0, lo=0, busy=0, done=0, dz=0, aborting any operation in progress with no done pulse.
REQ-030 After rst_n rises, the first rising edge SHALL accept a start normally.

Verification (WIDTH=32)
REQ-031 SLT a=0xFFFFFFFF b=1 -> y=1, z=0; SLTU same -> y=0, z=1; ADD 0x7FFFFFFF+1 -> y=0x80000000, ovf=1.
REQ-032 MULT a=0xFFFFFFFD b=7 -> busy 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=2 -> lo=3, hi=1.
REQ-034 DIVU a=5 b=0 -> done one cycle after start, lo=0xFFFFFFFF, hi=5, dz=1; next MULTU clears dz.
REQ-035 rst_n low during cycle 10 of MULTU -> busy=0, hi=lo=0 at once, no done ever pulses.
REQ-036 start with new op during RUN -> ignored, first result unchanged; start in FIN -> accepted, second done 33 cycles later.
